// File: rtl/click_counter.sv
// ----------------------------------------------------------------------------
// click_counter
//
// Groups press strobes from the debounce stage into a multi-click gesture
// (single, double, triple...). Presses that arrive within WINDOW_MS of the
// previous press belong to the same gesture. When the window runs out, or
// when the MAX_CLICKS-th press arrives, the gesture is reported once as a
// count on a valid/ready handshake.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   press_i        one-cycle press strobe from debounce
//   click_valid_o  gesture result available
//   click_ready_i  consumer accepts the result
//   click_count_o  presses in the gesture (1..MAX_CLICKS), stable while valid
//   click_drop_o   one-cycle pulse, a press was discarded while a result
//                  was waiting for acceptance
//
// All outputs come straight from flops. No input reaches an output
// combinationally.
// ----------------------------------------------------------------------------
module click_counter #(
    parameter int CLK_FREQ   = 50000000,
    parameter int WINDOW_MS  = 300,
    parameter int MAX_CLICKS = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              press_i,
    output logic                              click_valid_o,
    input  logic                              click_ready_i,
    output logic [$clog2(MAX_CLICKS+1)-1:0]   click_count_o,
    output logic                              click_drop_o
);

    // Window length in cycles. The timer width is kept at least one bit so
    // that a one-cycle window still elaborates cleanly.
    localparam int W  = CLK_FREQ / 1000 * WINDOW_MS;
    localparam int TW = (W > 1) ? $clog2(W) : 1;
    localparam int CW = $clog2(MAX_CLICKS + 1);

    localparam logic [TW-1:0] W_M1    = TW'(W - 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_CLICKS);
    localparam logic [CW-1:0] MAX_M1  = CW'(MAX_CLICKS - 1);

    // With MAX_CLICKS of one, the first press already completes a gesture.
    localparam bit SINGLE_SHOT = (MAX_CLICKS == 1);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        EMIT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   count_q, count_d;
    logic            drop_q,  drop_d;

    // Next-state logic for the gesture FSM.
    // The timer holds the number of further idle edges that are still
    // allowed before the gesture closes. A press on the edge where it reads
    // zero still counts, so a gap of exactly W cycles extends the gesture.
    // In COUNT, cnt is always below MAX_CLICKS, so reaching MAX_M1 means
    // this press completes the gesture and cnt can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        drop_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (press_i) begin
                    cnt_d   = CW'(1);
                    timer_d = W_M1;
                    state_d = SINGLE_SHOT ? EMIT : COUNT;
                end
            end

            COUNT: begin
                if (press_i) begin
                    if (cnt_q == MAX_M1) begin
                        cnt_d   = MAX_CNT;
                        state_d = EMIT;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        timer_d = W_M1;
                    end
                end else if (timer_q == '0) begin
                    state_d = EMIT;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            EMIT: begin
                if (click_ready_i) begin
                    if (press_i) begin
                        cnt_d   = CW'(1);
                        timer_d = W_M1;
                        state_d = SINGLE_SHOT ? EMIT : COUNT;
                    end else begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end else if (press_i) begin
                    drop_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                timer_d = '0;
            end
        endcase
    end

    // Output staging. The outputs are computed from the next state so that
    // they line up with the state register while still coming out of flops.
    // While a result is pending without a handshake, cnt_d equals cnt_q, so
    // the reported count holds steady until the consumer takes it.
    always_comb begin
        valid_d = (state_d == EMIT);
        count_d = (state_d == EMIT) ? cnt_d : '0;
    end

    // State, counter, timer and output registers. Reset clears everything,
    // including any pending result, without raising a drop pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            timer_q <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            valid_q <= valid_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    assign click_valid_o = valid_q;
    assign click_count_o = count_q;
    assign click_drop_o  = drop_q;

endmodule

// File: tb/tb_click_counter.sv
// ----------------------------------------------------------------------------
// tb_click_counter
//
// Self-checking bench for click_counter with CLK_FREQ=1000, WINDOW_MS=10
// (a 10-cycle window) and MAX_CLICKS=3. A per-edge vector table drives
// press/ready and holds the hand-computed valid/count/drop expected after
// each edge. Hand-written sequences then cover asynchronous reset, both
// mid-gesture and with a pending result.
// ----------------------------------------------------------------------------
module tb_click_counter;

    localparam int NV = 200;

    logic       clk;
    logic       rst_n;
    logic       press;
    logic       ready;
    logic       valid;
    logic [1:0] count;
    logic       drop;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       press;
        logic       ready;
        logic       expValid;
        logic [1:0] expCount;
        logic       expDrop;
    } vec_t;

    vec_t vecs [0:NV];

    click_counter #(
        .CLK_FREQ   (1000),
        .WINDOW_MS  (10),
        .MAX_CLICKS (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .press_i       (press),
        .click_valid_o (valid),
        .click_ready_i (ready),
        .click_count_o (count),
        .click_drop_o  (drop)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequencing ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of inputs, let the next rising edge take them, and
    // return 1 time unit after that edge so outputs are settled.
    task automatic applyStimulus(input logic p, input logic r);
        press = p;
        ready = r;
        @(posedge clk);
        #1;
    endtask

    // Compare the outputs against expectations. The count is only checked
    // when a result is expected to be visible.
    task automatic checkOutput(input string name, input logic expV,
                               input logic [1:0] expC, input logic expD,
                               input bit checkCnt);
        checks++;
        if (valid !== expV) begin
            errors++;
            $display("[TB] FAIL %s valid: got %b, expected %b", name, valid, expV);
        end
        checks++;
        if (drop !== expD) begin
            errors++;
            $display("[TB] FAIL %s drop: got %b, expected %b", name, drop, expD);
        end
        if (checkCnt) begin
            checks++;
            if (count !== expC) begin
                errors++;
                $display("[TB] FAIL %s count: got %0d, expected %0d", name, count, expC);
            end
        end
    endtask

    task automatic setPress(input int e);
        vecs[e].press = 1'b1;
    endtask

    task automatic setReady(input int from, input int to, input logic r);
        for (int e = from; e <= to; e++) vecs[e].ready = r;
    endtask

    task automatic setValid(input int from, input int to, input logic [1:0] c);
        for (int e = from; e <= to; e++) begin
            vecs[e].expValid = 1'b1;
            vecs[e].expCount = c;
        end
    endtask

    task automatic setDrop(input int e);
        vecs[e].expDrop = 1'b1;
    endtask

    initial begin
        // Vector table: entry e gives the inputs sampled at edge e and the
        // outputs expected just after edge e. Edge 0 is the reset release.
        for (int e = 0; e <= NV; e++) begin
            vecs[e].press    = 1'b0;
            vecs[e].ready    = 1'b1;
            vecs[e].expValid = 1'b0;
            vecs[e].expCount = 2'd0;
            vecs[e].expDrop  = 1'b0;
        end

        // Single press: window expires 10 edges later, taken immediately.
        setPress(5);
        setValid(15, 15, 2'd1);

        // Second press on the last edge of the window still counts.
        setPress(25);
        setPress(35);
        setValid(45, 45, 2'd2);

        // Third press closes the gesture at once; a later press is fresh.
        setPress(55);
        setPress(58);
        setPress(59);
        setValid(59, 59, 2'd3);
        setPress(80);
        setValid(90, 90, 1'd1);

        // Consumer stalled: presses are dropped, count holds, then accept.
        setReady(100, 124, 1'b0);
        setPress(105);
        setValid(115, 124, 2'd1);
        setPress(120);
        setPress(122);
        setDrop(120);
        setDrop(122);

        // Handshake and press on the same edge starts a new gesture.
        setPress(130);
        setReady(141, 149, 1'b0);
        setValid(140, 149, 2'd1);
        setPress(150);
        setValid(160, 160, 2'd1);

        // Back-to-back strobes each count.
        setPress(170);
        setPress(171);
        setValid(181, 181, 2'd2);
        setPress(190);
        setPress(191);
        setPress(192);
        setValid(192, 192, 2'd3);

        // Reset state.
        rst_n = 1'b0;
        press = 1'b0;
        ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 2'd0, 1'b0, 1'b1);
        rst_n = 1'b1;

        for (int e = 1; e <= NV; e++) begin
            applyStimulus(vecs[e].press, vecs[e].ready);
            checkOutput($sformatf("vec%0d", e), vecs[e].expValid,
                        vecs[e].expCount, vecs[e].expDrop, vecs[e].expValid);
        end

        // Asynchronous reset mid-gesture: press at rel 5, reset inside the
        // cycle after rel 9, release after rel 12. Without the reset a result
        // would appear after rel 15.
        repeat (4) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_gesture", 1'b0, 2'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        repeat (2) applyStimulus(1'b0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("post_rst_idle%0d", i), 1'b0, 2'd0, 1'b0, 1'b0);
        end

        // Asynchronous reset with a pending result and a drop pulse showing:
        // every output must clear at once.
        applyStimulus(1'b1, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0);
        checkOutput("pending_before_rst", 1'b1, 2'd1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("drop_before_rst", 1'b1, 2'd1, 1'b1, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_in_emit", 1'b0, 2'd0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("post_emit_rst%0d", i), 1'b0, 2'd0, 1'b0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/click_counter.md
# click_counter

Counts button-press strobes that arrive within a configurable inter-press window and reports the total (single, double, triple… click) as one event. It sits directly downstream of the debounce stage (STROBE enabled) and takes its one-cycle `press` pulse. The result goes to control logic over a valid/ready handshake. All logic runs in the same fast `clk` domain as the debounce strobe.

## Interface
- CLK_FREQ, 50000000: clk frequency in Hz.
- WINDOW_MS, 300: maximum gap, in ms, between consecutive presses of one gesture.
- MAX_CLICKS, 3: press count that terminates a gesture immediately (≥1).
- Derived: W = CLK_FREQ/1000*WINDOW_MS cycles (≥1); TW = $clog2(W); CW = $clog2(MAX_CLICKS+1).

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low. All flops clear immediately on assertion; deassertion is synchronous to clk upstream.
- press  in  1  one-cycle press strobe from debounce.
- click_valid  out  1  gesture result available.
- click_ready  in  1  consumer accepts result.
- click_count  out  CW  presses in the gesture (1..MAX_CLICKS); stable while click_valid.
- click_drop  out  1  one-cycle pulse: a press was discarded while a result awaited acceptance.

## Operation
- States: IDLE, COUNT, EMIT. Reset → IDLE, cnt=0, timer=0, click_valid=0, click_drop=0, click_count=0.
- IDLE:
  - press → cnt=1, timer=W-1.
  - If MAX_CLICKS==1 → EMIT, else → COUNT.
- COUNT, on each edge:
  - press:
    - cnt+1 == MAX_CLICKS → cnt=MAX_CLICKS, → EMIT.
    - else cnt+1, timer=W-1, stay.
  - no press, timer==0 → EMIT.
  - no press, timer>0 → timer-1.
- A press on the edge where timer==0 is accepted (counts), not expired.
- EMIT:
  - click_valid=1, click_count=cnt.
  - On an edge with click_ready=1 the handshake completes:
    - press on the same edge → cnt=1, timer=W-1, → COUNT (→ EMIT if MAX_CLICKS==1, new result).
    - else → IDLE, cnt=0.
  - press without click_ready → press discarded, click_drop=1 for the next cycle, cnt unchanged.
- click_valid never drops without a handshake. click_count changes only on handshake or a new EMIT entry.
- cnt saturates at MAX_CLICKS and never wraps. The timer never underflows.
- rst_n asserted mid-gesture or in EMIT → immediate return to reset values. A pending result is lost, with no drop pulse.

## Timing
- All outputs registered; no combinational path input→output.
- Last press at edge t with no further press → click_valid rises after edge t+W. Latency is W+1 cycles from the press cycle to the valid cycle.
- A press at any edge t+1..t+W extends the gesture.
- MAX_CLICKS-th press at edge t → click_valid high after edge t, with no window wait.
- Handshake at edge h → click_valid low after edge h (or high again after h+1 edges per rules above).
- Back-to-back press strobes on consecutive cycles are legal and each counts.
- click_drop is a single-cycle pulse per discarded press, aligned one cycle after that press.

## Test plan
Bench parameters: CLK_FREQ=1000, WINDOW_MS=10 (W=10), MAX_CLICKS=3, click_ready=1 unless stated.
- Single press at edge 5 → click_valid high exactly after edge 15 for one cycle, click_count=1. No further activity.
- Presses at edges 5, 15 (timer==0 boundary) → one gesture. click_valid after edge 25, click_count=2.
- Presses at 5, 8, 9 → MAX reached. click_valid after edge 9, click_count=3, no window wait. A press at 30 starts a fresh gesture, reported at 40 with count 1.
- click_ready=0, single press at 5 (valid from 15), presses at 20, 22 → click_drop pulses after 20 and 22, click_count stays 1. Raise click_ready at 25 → valid low after 25, back to IDLE.
- Result pending, click_ready and press both high at edge 30 → handshake completes and a new gesture starts. click_valid after 40, count 1.
- Press at 5, rst_n low at 9 (asynchronous, mid-cycle) → all outputs 0 immediately. Release at 12 → no click_valid ever appears without a new press.
